// File: rtl/aon_rtc_pkg.sv
// Shared register addresses, CFG field positions and reset constants for the AON RTC.
package aon_rtc_pkg;

  localparam logic [2:0] RTC_CFG    = 3'd0;
  localparam logic [2:0] RTC_CNT_LO = 3'd1;
  localparam logic [2:0] RTC_CNT_HI = 3'd2;
  localparam logic [2:0] RTC_S      = 3'd3;
  localparam logic [2:0] RTC_CMP    = 3'd4;

  localparam int CFG_SCALE_LSB = 0;
  localparam int CFG_EN_BIT    = 12;
  localparam int CFG_IP_BIT    = 28;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/aon_rtc_counter.sv
// AON real-time counter: free-running 48-bit count with power-of-two prescale,
// 32-bit compare producing a level interrupt, and a small synchronised register port.
module aon_rtc_counter
  import aon_rtc_pkg::*;
#(
  parameter int CNT_W   = 48,
  parameter int CMP_W   = 32,
  parameter int SCALE_W = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [2:0]       reg_addr,
  input  logic [CMP_W-1:0] reg_wdata,
  output logic [CMP_W-1:0] reg_rdata,
  output logic             reg_rvalid,
  output logic             rtc_tick,
  output logic             irq
);

  logic [CNT_W-1:0]   count_q, count_d, count_inc, shifted, tick_mask;
  logic [CMP_W-1:0]   s, cmp_q, cmp_d, rdata_q, rdata_d, cfg_rd;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic               en_q, en_d, irq_q, irq_d, tick_q, tick_d, rvalid_q, rvalid_d;
  logic               wr_lo, wr_hi;

  always_comb begin
    count_inc = count_q + CNT_W'(1);
    shifted   = count_q >> scale_q;
    s         = shifted[CMP_W-1:0];
    tick_mask = (CNT_W'(1) << scale_q) - CNT_W'(1);
    wr_lo     = reg_wr && (reg_addr == RTC_CNT_LO);
    wr_hi     = reg_wr && (reg_addr == RTC_CNT_HI);

    // A software write to either half of the count suppresses that cycle's increment.
    count_d = en_q ? count_inc : count_q;
    if (wr_lo || wr_hi) begin
      count_d = count_q;
      if (wr_lo) count_d[31:0] = reg_wdata;
      if (wr_hi) count_d[CNT_W-1:32] = reg_wdata[CNT_W-33:0];
    end

    tick_d = en_q && !(wr_lo || wr_hi) && ((count_inc & tick_mask) == '0);
    irq_d  = (s >= cmp_q);

    scale_d = scale_q;
    en_d    = en_q;
    if (reg_wr && (reg_addr == RTC_CFG)) begin
      scale_d = reg_wdata[CFG_SCALE_LSB +: SCALE_W];
      en_d    = reg_wdata[CFG_EN_BIT];
    end
    cmp_d = (reg_wr && (reg_addr == RTC_CMP)) ? reg_wdata : cmp_q;

    cfg_rd                                 = '0;
    cfg_rd[CFG_SCALE_LSB +: SCALE_W]       = scale_q;
    cfg_rd[CFG_EN_BIT]                     = en_q;
    cfg_rd[CFG_IP_BIT]                     = irq_q;

    rvalid_d = reg_rd;
    rdata_d  = rdata_q;
    if (reg_rd) begin
      case (reg_addr)
        RTC_CFG:    rdata_d = cfg_rd;
        RTC_CNT_LO: rdata_d = count_q[31:0];
        RTC_CNT_HI: rdata_d = CMP_W'(count_q[CNT_W-1:32]);
        RTC_S:      rdata_d = s;
        RTC_CMP:    rdata_d = cmp_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      count_q  <= '0;
      scale_q  <= '0;
      en_q     <= 1'b0;
      cmp_q    <= CMP_RST;
      irq_q    <= 1'b0;
      tick_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      scale_q  <= scale_d;
      en_q     <= en_d;
      cmp_q    <= cmp_d;
      irq_q    <= irq_d;
      tick_q   <= tick_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign rtc_tick   = tick_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_aon_rtc_counter.sv
// Directed bench for aon_rtc_counter: reads are scoreboarded, irq/tick checked inline.
module tb_aon_rtc_counter;
  import aon_rtc_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [2:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        rtc_tick;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  aon_rtc_counter dut (
    .clk_in(clk_in), .rst(rst), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .rtc_tick(rtc_tick), .irq(irq)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    reg_wr = 1'b0;
    reg_rd = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    reg_wr = 1'b1;
    reg_addr = addr;
    reg_wdata = data;
    step();
  endtask

  // Issue a read strobe for the current cycle; caller advances the clock.
  task automatic issue_rd(input logic [2:0] addr, input logic [31:0] exp);
    reg_rd = 1'b1;
    reg_addr = addr;
    exp_q.push_back(exp);
  endtask

  always @(negedge clk_in) begin
    if (reg_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected actual=1 expected=0 t=%0t", $time);
      end else begin
        check("read_data", reg_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    rst = 1'b0;
    @(negedge clk_in);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_tick", {31'd0, rtc_tick}, 32'd0);
    check("rst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    step();
    issue_rd(RTC_CMP, 32'hFFFF_FFFF); step();
    issue_rd(RTC_CFG, 32'd0); step();
    wr(3'd6, 32'hDEAD_BEEF);
    issue_rd(3'd6, 32'd0); step();
    issue_rd(RTC_CNT_LO, 32'd0); step();

    // scale 0: count j after enable edge; irq one cycle after s reaches 5
    wr(RTC_CMP, 32'd5);
    wr(RTC_CFG, 32'h0000_1000);
    for (int j = 0; j <= 8; j++) begin
      issue_rd(RTC_S, 32'(j));
      @(negedge clk_in);
      check("s0_irq", {31'd0, irq}, (j >= 6) ? 32'd1 : 32'd0);
      check("s0_tick", {31'd0, rtc_tick}, (j >= 1) ? 32'd1 : 32'd0);
      step();
    end
    issue_rd(RTC_CFG, 32'h1000_1000); step();

    // scale 3: tick every 8 counts, S = count/8
    wr(RTC_CFG, 32'h0000_0003);
    wr(RTC_CNT_LO, 32'd0);
    wr(RTC_CNT_HI, 32'd0);
    wr(RTC_CMP, 32'hFFFF_FFFF);
    wr(RTC_CFG, 32'h0000_1003);
    for (int j = 0; j <= 40; j++) begin
      if (j == 39) issue_rd(RTC_S, 32'd4);
      if (j == 40) issue_rd(RTC_S, 32'd5);
      @(negedge clk_in);
      check("s3_tick", {31'd0, rtc_tick}, (j >= 1 && (j % 8) == 0) ? 32'd1 : 32'd0);
      step();
    end

    // wrap from all-ones to zero; irq drops once s < cmp
    wr(RTC_CFG, 32'h0000_0000);
    wr(RTC_CNT_LO, 32'hFFFF_FFFF);
    wr(RTC_CNT_HI, 32'hFFFF_FFFF);
    wr(RTC_CMP, 32'h0000_0010);
    wr(RTC_CFG, 32'h0000_1000);
    issue_rd(RTC_S, 32'hFFFF_FFFF);
    @(negedge clk_in);
    check("wrap_irq_hi", {31'd0, irq}, 32'd1);
    step();
    issue_rd(RTC_S, 32'd0);
    @(negedge clk_in);
    check("wrap_irq_lag", {31'd0, irq}, 32'd1);
    check("wrap_tick", {31'd0, rtc_tick}, 32'd1);
    step();
    issue_rd(RTC_CNT_HI, 32'd0);
    @(negedge clk_in);
    check("wrap_irq_clr", {31'd0, irq}, 32'd0);
    step();

    // count write wins over increment; same-cycle read returns pre-write value
    reg_wr = 1'b1; reg_wdata = 32'h10;
    issue_rd(RTC_CNT_LO, 32'd2);
    step();
    issue_rd(RTC_CNT_LO, 32'h10);
    @(negedge clk_in);
    check("wr_no_tick", {31'd0, rtc_tick}, 32'd0);
    check("wr_irq_old", {31'd0, irq}, 32'd0);
    step();
    issue_rd(RTC_CNT_LO, 32'h11);
    @(negedge clk_in);
    check("wr_tick_resume", {31'd0, rtc_tick}, 32'd1);
    check("wr_irq_set", {31'd0, irq}, 32'd1);
    step();

    // raising cmp clears irq one cycle later
    reg_wr = 1'b1; reg_wdata = 32'h1000;
    issue_rd(RTC_CMP, 32'h10);
    step();
    @(negedge clk_in);
    check("cmp_irq_lag", {31'd0, irq}, 32'd1);
    step();
    @(negedge clk_in);
    check("cmp_irq_clr", {31'd0, irq}, 32'd0);
    step();

    // reset with irq high and a read in flight
    wr(RTC_CMP, 32'd0);
    step();
    @(negedge clk_in);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    step();
    reg_rd = 1'b1; reg_addr = RTC_CFG; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk_in);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    check("mid_rst_tick", {31'd0, rtc_tick}, 32'd0);
    check("mid_rst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    check("mid_rst_rdata", reg_rdata, 32'd0);
    step();
    issue_rd(RTC_CMP, 32'hFFFF_FFFF); step();
    issue_rd(RTC_CNT_LO, 32'd0); step();
    issue_rd(RTC_CFG, 32'd0); step();

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
